// File: rtl/text_entry_pkg.sv
// ============================================================================
// Module   : text_entry_pkg
// Purpose  : Shared constants and FSM state type for the text entry writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package text_entry_pkg;

    localparam int         NUM_SLOTS           = 7;
    localparam logic [3:0] CHECK_IDLE          = 4'hF;
    localparam int         DEFAULT_BLANK_INDEX = 36;
    localparam int         DEFAULT_CHAR_COUNT  = 37;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/text_entry_writer_if.sv
// ============================================================================
// Module   : text_entry_writer_if
// Purpose  : Slot-write bus from the text entry writer to the effect blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface text_entry_writer_if;

    logic [3:0] check;
    logic [6:0] text_index;
    logic       busy;

    modport master (output check, output text_index, output busy);
    modport slave  (input  check, input  text_index, input  busy);

endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-FF synchroniser, level debouncer and one-cycle press pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Counter only runs while the synced level disagrees with the accepted one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/text_entry_writer.sv
// ============================================================================
// Module   : text_entry_writer
// Purpose  : Button-driven 7-character editor that sweeps its buffer onto the
//            shared (check, text_index) slot-write bus on commit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module text_entry_writer
    import text_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CHAR_COUNT      = DEFAULT_CHAR_COUNT,
    parameter int BLANK_INDEX     = DEFAULT_BLANK_INDEX,
    parameter int AUTO_COMMIT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_next_n,
    input  logic                       key_inc_n,
    input  logic                       key_dec_n,
    input  logic                       key_commit_n,
    text_entry_writer_if.master        bus,
    output logic [2:0]                 cursor,
    output logic [6:0]                 edit_char
);

    logic [3:0] w_keys_n;
    logic [3:0] w_press;
    logic       w_next;
    logic       w_inc;
    logic       w_dec;
    logic       w_req;

    logic [6:0] r_buf [NUM_SLOTS];
    logic [2:0] r_cursor;
    state_t     r_state;
    logic [2:0] r_slot;
    logic       r_pending;
    logic       r_init;
    logic [3:0] r_check;
    logic [6:0] r_text;
    logic       r_busy;

    assign w_keys_n = {key_commit_n, key_dec_n, key_inc_n, key_next_n};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn (
                .clk   (clk),
                .rst   (rst),
                .key_n (w_keys_n[gi]),
                .press (w_press[gi])
            );
        end
    endgenerate

    assign w_next = w_press[0];
    assign w_inc  = w_press[1] & ~w_press[2];
    assign w_dec  = w_press[2] & ~w_press[1];
    // r_init turns the first cycle after reset into a blank-buffer publish
    assign w_req  = w_press[3] | r_init | ((AUTO_COMMIT != 0) & (w_inc | w_dec));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_buf[i] <= 7'(BLANK_INDEX);
            end
            r_cursor <= '0;
        end else begin
            if (w_inc) begin
                r_buf[r_cursor] <= (r_buf[r_cursor] == 7'(CHAR_COUNT - 1)) ?
                                   7'd0 : r_buf[r_cursor] + 7'd1;
            end
            if (w_dec) begin
                r_buf[r_cursor] <= (r_buf[r_cursor] == 7'd0) ?
                                   7'(CHAR_COUNT - 1) : r_buf[r_cursor] - 7'd1;
            end
            if (w_next) begin
                r_cursor <= (r_cursor == 3'(NUM_SLOTS - 1)) ? 3'd0 : r_cursor + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_slot    <= '0;
            r_pending <= 1'b0;
            r_init    <= 1'b1;
            r_check   <= CHECK_IDLE;
            r_text    <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_init <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state   <= WRITE;
                        r_slot    <= '0;
                        r_check   <= 4'd0;
                        r_text    <= r_buf[0];
                        r_busy    <= 1'b1;
                        r_pending <= 1'b0;
                    end
                end
                WRITE: begin
                    if (w_req) begin
                        r_pending <= 1'b1;
                    end
                    if (r_slot == 3'(NUM_SLOTS - 1)) begin
                        r_state <= GAP;
                        r_check <= CHECK_IDLE;
                    end else begin
                        r_slot  <= r_slot + 3'd1;
                        r_check <= {1'b0, r_slot + 3'd1};
                        r_text  <= r_buf[r_slot + 3'd1];
                    end
                end
                GAP: begin
                    // Any number of requests seen during the sweep yield one rerun
                    if (r_pending | w_req) begin
                        r_state   <= WRITE;
                        r_slot    <= '0;
                        r_check   <= 4'd0;
                        r_text    <= r_buf[0];
                        r_pending <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_check <= CHECK_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.check      = r_check;
    assign bus.text_index = r_text;
    assign bus.busy       = r_busy;
    assign cursor         = r_cursor;
    assign edit_char      = r_buf[r_cursor];

endmodule

`default_nettype wire
